// File: rtl/jerky_counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : jerky_counter_sched
// Description : Round-robin run scheduler for a shared jerky counter. Grants
//               one of two requesters, pulses the counter clear, holds the
//               counter enable for the owner's programmed run length, ends
//               the run early on request withdrawal and reports completion.
//               All outputs are decoded from registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module jerky_counter_sched #(
    parameter int counter_size = 5,
    parameter int LEN_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             cnt_clear,
    output logic             cnt_enable,
    output logic             done,
    output logic             aborted
);

    // State encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CLEAR = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_LEN_ZERO = '0;

    // The counter width is only carried for integration; reject a
    // meaningless configuration at elaboration time.
    generate
        if (counter_size < 1) begin : g_bad_counter_size
            $error("jerky_counter_sched: counter_size must be at least 1");
        end
    endgenerate

    logic [1:0]       r_state;
    logic             r_owner;        // 0 = requester 0, 1 = requester 1
    logic             r_last_owner;   // owner of the most recently finished run
    logic             r_aborted;      // exit reason of the current run
    logic [LEN_W-1:0] r_remaining;    // enable cycles still to issue

    logic             w_winner;
    logic [LEN_W-1:0] w_winner_len;

    // Arbitration: a lone requester wins; on a tie the one that did not own
    // the previous run wins.
    always_comb begin
        w_winner = 1'b0;
        case (req)
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last_owner;
            default: w_winner = 1'b0;
        endcase
        w_winner_len = w_winner ? len1 : len0;
    end

    // Run sequencing: IDLE -> CLEAR -> RUN (0..L cycles) -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_aborted    <= 1'b0;
            r_remaining  <= c_LEN_ZERO;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req != 2'b00) begin
                        r_owner     <= w_winner;
                        r_remaining <= w_winner_len;
                        r_aborted   <= 1'b0;
                        r_state     <= c_CLEAR;
                    end
                end
                c_CLEAR: begin
                    // Withdrawal during CLEAR is deliberately not looked at;
                    // it is caught on the first RUN cycle.
                    r_aborted <= 1'b0;
                    r_state   <= (r_remaining != c_LEN_ZERO) ? c_RUN : c_DONE;
                end
                c_RUN: begin
                    r_remaining <= r_remaining - c_LEN_ONE;
                    if (r_remaining == c_LEN_ONE) begin
                        // Completion takes priority over a same-cycle withdrawal
                        r_aborted <= 1'b0;
                        r_state   <= c_DONE;
                    end else if (!req[r_owner]) begin
                        r_aborted <= 1'b1;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_last_owner <= r_owner;
                    r_state      <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Moore output decode
    assign busy       = (r_state != c_IDLE);
    assign grant      = busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign cnt_clear  = (r_state == c_CLEAR);
    assign cnt_enable = (r_state == c_RUN);
    assign done       = (r_state == c_DONE);
    assign aborted    = done & r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_jerky_counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_jerky_counter_sched
// Description : Directed self-checking bench for jerky_counter_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jerky_counter_sched;

    localparam int LEN_W = 8;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req   = 2'b00;
    logic [LEN_W-1:0] len0  = '0;
    logic [LEN_W-1:0] len1  = '0;
    logic [1:0]       grant;
    logic             busy;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             done;
    logic             aborted;

    int n_checks = 0;
    int n_errors = 0;

    jerky_counter_sched #(
        .counter_size (5),
        .LEN_W        (LEN_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .grant      (grant),
        .busy       (busy),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .done       (done),
        .aborted    (aborted)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follow one run from CLEAR to DONE. drop_at: RUN cycle during which the
    // owner's request is lowered (0 = never). chg_at: RUN cycle during which
    // len0 is changed to 2 and req[1] is raised (0 = never).
    task automatic watch_run(input int drop_at, input int chg_at,
                             output int n_en, output int span, output int wait_t,
                             output logic [1:0] g, output logic ab);
        int n_clr   = 0;
        int gstable = 1;
        int ovl     = 0;
        n_en = 0; span = 0; wait_t = 0; g = 2'b00; ab = 1'b0;
        while (cnt_clear !== 1'b1 && wait_t < 50) begin
            tick();
            wait_t++;
        end
        check("clear_seen", int'(cnt_clear === 1'b1), 1);
        if (cnt_clear !== 1'b1) return;
        g = grant;
        n_clr = 1;
        while (done !== 1'b1 && span < 300) begin
            tick();
            span++;
            if (grant !== g) gstable = 0;
            if (cnt_clear === 1'b1) n_clr++;
            if (cnt_clear === 1'b1 && cnt_enable === 1'b1) ovl = 1;
            if (cnt_enable === 1'b1) begin
                n_en++;
                if (n_en == drop_at) req[g[1]] = 1'b0;
                if (n_en == chg_at) begin
                    len0   = 8'd2;
                    req[1] = 1'b1;
                end
            end
        end
        check("done_seen", int'(done === 1'b1), 1);
        check("clear_once", n_clr, 1);
        check("grant_stable", gstable, 1);
        check("clear_enable_overlap", ovl, 0);
        ab = aborted;
    endtask

    int         n_en, span, wait_t;
    logic [1:0] g;
    logic       ab;
    int         w;

    initial begin
        // Power-on reset
        tick();
        tick();
        check("reset_outputs", int'({grant, busy, cnt_clear, cnt_enable, done, aborted}), 0);

        // Reset in the middle of a run
        reset = 1'b0;
        req   = 2'b01;
        len0  = 8'd10;
        w = 0;
        while (cnt_clear !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("rst_run_clear", int'(cnt_clear === 1'b1), 1);
        tick();
        tick();
        tick();
        check("rst_run_enable", int'(cnt_enable), 1);
        reset = 1'b1;
        tick();
        check("rst_midrun_outputs", int'({grant, busy, cnt_clear, cnt_enable, done, aborted}), 0);
        req  = 2'b11;
        len0 = 8'd2;
        len1 = 8'd7;
        tick();
        check("rst_held_outputs", int'({grant, busy, cnt_clear, cnt_enable, done, aborted}), 0);
        reset = 1'b0;
        watch_run(0, 0, n_en, span, wait_t, g, ab);
        req = 2'b00;
        check("rst_tie_grant", int'(g), 1);
        check("rst_tie_enables", n_en, 2);
        tick();
        check("rst_tie_idle_busy", int'(busy), 0);

        // Single run of length 5
        req  = 2'b01;
        len0 = 8'd5;
        watch_run(0, 0, n_en, span, wait_t, g, ab);
        req = 2'b00;
        check("single_grant", int'(g), 1);
        check("single_enables", n_en, 5);
        check("single_span", span, 6);
        check("single_aborted", int'(ab), 0);
        tick();
        check("single_done_pulse", int'(done), 0);
        check("single_idle_busy", int'(busy), 0);

        // Zero-length run on requester 1
        req  = 2'b10;
        len1 = 8'd0;
        watch_run(0, 0, n_en, span, wait_t, g, ab);
        req = 2'b00;
        check("zero_grant", int'(g), 2);
        check("zero_enables", n_en, 0);
        check("zero_span", span, 1);
        check("zero_aborted", int'(ab), 0);
        tick();
        check("zero_idle_busy", int'(busy), 0);

        // Round-robin with both requesters held
        len0 = 8'd3;
        len1 = 8'd4;
        req  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            watch_run(0, 0, n_en, span, wait_t, g, ab);
            check($sformatf("rr%0d_grant", i), int'(g), (i % 2 == 1) ? 2 : 1);
            check($sformatf("rr%0d_enables", i), n_en, (i % 2 == 1) ? 4 : 3);
            check($sformatf("rr%0d_aborted", i), int'(ab), 0);
            if (i > 0) check($sformatf("rr%0d_gap", i), wait_t, 2);
        end
        req = 2'b00;
        tick();
        check("rr_idle_busy", int'(busy), 0);

        // Abort on the 3rd RUN cycle
        len0 = 8'd8;
        req  = 2'b01;
        watch_run(3, 0, n_en, span, wait_t, g, ab);
        check("abort_grant", int'(g), 1);
        check("abort_enables", n_en, 3);
        check("abort_span", span, 4);
        check("abort_flag", int'(ab), 1);
        tick();
        check("abort_idle_busy", int'(busy), 0);

        // Withdrawal on the last RUN cycle: completion wins
        req = 2'b01;
        watch_run(8, 0, n_en, span, wait_t, g, ab);
        check("lastcyc_enables", n_en, 8);
        check("lastcyc_aborted", int'(ab), 0);
        tick();
        check("lastcyc_idle_busy", int'(busy), 0);

        // len0 change and req1 rising mid-run
        len0 = 8'd8;
        len1 = 8'd3;
        req  = 2'b01;
        watch_run(0, 2, n_en, span, wait_t, g, ab);
        check("lenchg_grant", int'(g), 1);
        check("lenchg_enables", n_en, 8);
        check("lenchg_aborted", int'(ab), 0);
        watch_run(0, 0, n_en, span, wait_t, g, ab);
        req = 2'b00;
        check("lenchg_next_grant", int'(g), 2);
        check("lenchg_next_enables", n_en, 3);
        check("lenchg_next_gap", wait_t, 2);
        tick();
        check("final_idle_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jerky_counter_sched.md
# jerky_counter_sched

Run scheduler for the jerky counter datapath. Two requesters share one counter instance; this block arbitrates between them round-robin, clears the counter at the start of each granted run, and holds the counter enable high for a per-requester programmed number of cycles. It also ends a run early if the owner withdraws its request, then reports completion. It sits between the requesting logic and the counter's enable/clear inputs.

## Interface
- counter_size, 5, width of the controlled counter; carried for integration and probe width, not used in scheduling arithmetic
- LEN_W, 8, width of run-length inputs and internal remaining-cycle counter
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; forces idle state
- req  in  2  per-requester run request, level; held high for the duration of a wanted run
- len0  in  LEN_W  run length (enable cycles) for requester 0, sampled at grant
- len1  in  LEN_W  run length for requester 1, sampled at grant
- grant  out  2  one-hot owner of the counter; 0 when idle
- busy  out  1  high in any state other than IDLE
- cnt_clear  out  1  one-cycle clear pulse to counter at run start
- cnt_enable  out  1  counter enable; high only in RUN
- done  out  1  one-cycle pulse at run end
- aborted  out  1  valid with done; 1 if run ended by request withdrawal

## Operation
- States: IDLE, CLEAR, RUN, DONE. State, owner, remaining and rr pointer are registers; every output is decoded from registered state only (Moore), never from req/len in the same cycle.
- IDLE: outputs all 0. If req != 0: winner = the only requester asserting; if both, the one != last_owner. Latch owner, remaining = len of winner, go CLEAR.
- CLEAR: grant[owner]=1, cnt_clear=1, busy=1. Next: RUN if remaining != 0, else DONE (aborted=0). Zero length yields zero enable cycles.
- RUN: grant, busy, cnt_enable = 1. Each cycle remaining decrements by 1. If remaining == 1 → DONE, aborted=0. Else if req[owner]==0 → DONE, aborted=1. Completion wins over withdrawal in the same cycle.
- DONE: grant[owner]=1, busy=1, done=1, aborted per above; last_owner <= owner; next IDLE.
- req[owner] withdrawn in CLEAR: ignored; the run proceeds to RUN, and the withdrawal is detected on the first RUN cycle.
- Non-owner req never affects an ongoing run; it is served at the next IDLE.
- len inputs are sampled only on the IDLE→CLEAR transition; changes mid-run are ignored.
- Arithmetic: remaining is LEN_W bits unsigned, max run 2^LEN_W−1 enable cycles; no wrap because decrement stops at exit from RUN.

## Timing
- Reset (any state, mid-run included): next cycle state=IDLE, grant=0, busy=0, cnt_clear=0, cnt_enable=0, done=0, aborted=0, remaining=0, last_owner=1 so requester 0 wins the first tie.
- req sampled high in IDLE at edge N: CLEAR during cycle N+1; RUN cycles N+2 .. N+1+L; DONE at N+2+L; IDLE at N+3+L.
- Held req re-granted at the earliest after one IDLE cycle: a new CLEAR at N+4+L.
- L=0: CLEAR at N+1, DONE at N+2, IDLE at N+3.
- Abort: req[owner] sampled low on RUN cycle k (k < L): exactly k cnt_enable cycles, DONE next cycle with aborted=1.
- grant is stable from CLEAR through DONE inclusive; cnt_clear and cnt_enable are never high together.

## Test plan
- Reset mid-RUN (req0, len0=10, reset on 3rd RUN cycle) → next cycle all outputs 0, state IDLE; after release, a tie grants requester 0.
- Single run: req=01, len0=5, held → cnt_clear for 1 cycle, cnt_enable for exactly 5 cycles, done=1 with aborted=0, grant=01 throughout, 6 clk edges from CLEAR to DONE inclusive.
- Round-robin: req=11 held, len0=3, len1=4 → grant order 01,10,01,10; enable counts 3,4,3,4; one idle cycle between runs.
- Zero length: req=10, len1=0 → CLEAR then DONE, zero enable cycles, aborted=0.
- Abort: req=01, len0=8, drop req0 after the 3rd RUN cycle → 3 enable cycles, done=1, aborted=1. Dropping on the 8th RUN cycle → aborted=0.
- len change mid-run (len0 8→2 during RUN) and req1 rising mid-run → run still lasts 8 cycles; requester 1 is granted next.
